fdd_track_ctrl: RTL and testbench
=================================

# fdd_track_ctrl

Sequencer for the Disk II track buffer. It sits between the disk controller's track and buffer-write signals and SD channel 0. On a head-track change or image mount it writes back dirty sectors of the resident track and then loads the new track, 13 sectors of 256 bytes, into the floppy DPRAM. It stalls the CPU while it works.

## Interface
Parameters:
- SECTORS, default 13: sectors per track.
- TRACK_W, default 6: width of the track number.

Ports:
- clk_sys, in, 1: system clock. One clock for the whole block.
- reset_n, in, 1: reset. Asynchronous, active-low.
- track, in, TRACK_W: head track from the disk controller.
- img_mounted, in, 1: one-cycle pulse when a new image is attached.
- img_size_nz, in, 1: image size is non-zero. Sampled on img_mounted.
- img_readonly, in, 1: image is write-protected. Sampled on img_mounted.
- fd_write_disk, in, 1: buffer write strobe from the disk controller.
- fd_track_addr, in, 14: buffer address. Bits [12:9] give the sector slot.
- sd_lba, out, 32: sector LBA for channel 0.
- sd_rd, out, 1: read request.
- sd_wr, out, 1: write request.
- sd_ack, in, 1: SD acknowledge. Held high for the whole sector transfer.
- buf_sec, out, 4: sector slot. Drives DPRAM address bits [12:9] on the SD side.
- cpu_wait, out, 1: CPU stall.
- dirty, out, SECTORS: dirty-sector mask. Debug/status only.

## Operation
- Registered state: mounted, ro, cur_track, dirty[SECTORS-1:0], sec, mount_pend, and the FSM.
- FSM states: IDLE, FLUSH_REQ, FLUSH_XFER, LOAD_REQ, LOAD_XFER.
- Dirty tracking, IDLE only:
  - Sets dirty[fd_track_addr[12:9]] when fd_write_disk & mounted & ~ro & fd_track_addr[12:9] < SECTORS.
  - Slot values of SECTORS and above are ignored.
  - Strobes outside IDLE are dropped.
- Mount handling:
  - img_mounted sets mount_pend in any state and latches ro = img_readonly.
  - It also latches mounted = img_size_nz.
- IDLE, in priority order:
  - mount_pend: clear mount_pend and dirty. If mounted, cur_track <= track, sec <= 0, go to LOAD_REQ.
  - track != cur_track & mounted: cur_track_old is kept for the flush. If dirty != 0, sec <= lowest dirty index and go to FLUSH_REQ. Otherwise cur_track <= track, sec <= 0, go to LOAD_REQ.
  - track != cur_track & ~mounted: cur_track <= track only.
- FLUSH_REQ:
  - Drive sd_wr = 1 and sd_lba = cur_track*SECTORS + sec.
  - On ack rising edge, drop sd_wr, clear dirty[sec], go to FLUSH_XFER.
- FLUSH_XFER:
  - On ack falling edge, if dirty != 0, sec <= next lowest dirty index and go to FLUSH_REQ.
  - Otherwise cur_track <= track, sec <= 0, go to LOAD_REQ.
- LOAD_REQ:
  - Drive sd_rd = 1 and sd_lba = cur_track*SECTORS + sec.
  - On ack rising edge, drop sd_rd and go to LOAD_XFER.
- LOAD_XFER:
  - On ack falling edge, if mount_pend, go to IDLE, which restarts the sequence.
  - Else if sec == SECTORS-1, go to IDLE.
  - Else sec <= sec + 1 and go to LOAD_REQ.
- Mount pulse during a flush: when the current ack completes, dirty is cleared and the block returns to IDLE. Remaining write-backs are discarded.
- LBA arithmetic: computed at 10 bits and zero-extended to 32. Maximum value is 63*13+12 = 831.
- cpu_wait = (state != IDLE), or IDLE with a pending trigger. It is registered and rises with the first request.
- buf_sec = sec in all states.
- Edge detection: ack edges come from a registered copy of sd_ack, old_ack.

## Timing
- Reset values, asynchronous:
  - All outputs 0, sd_lba 0.
  - FSM IDLE, cur_track 0, mounted 0, ro 0, dirty 0, mount_pend 0, old_ack 0.
- Reset mid-transfer: sd_rd/sd_wr drop immediately. The SD side is expected to abort; no completion is tracked.
- Trigger to request: sd_rd/sd_wr and cpu_wait go high one cycle after the IDLE cycle that sees the trigger.
- sd_lba and buf_sec are stable from request assertion until ack falls.
- Request deassertion: one cycle after ack rises is seen (old_ack = 0, sd_ack = 1).
- Sector completion: one cycle after ack falls. The next request follows one cycle later.
- cpu_wait falls in the cycle the FSM enters IDLE after the last load sector.
- Load latency: 13 sector handshakes, plus 2 cycles per sector of overhead.
- Simultaneous events:
  - img_mounted in the same cycle as a track change: the mount wins and the flush is skipped.
  - fd_write_disk in the same cycle IDLE leaves: the dirty bit is set first, so it is included in the flush.

## Test plan
- Mount (size 143360, rw) with track = 0:
  - Required: 13 sd_rd handshakes with sd_lba 0..12 and buf_sec 0..12.
  - Required: cpu_wait high throughout and low after the 13th ack falls.
- Track 0→5 with dirty = 0:
  - Required: no sd_wr.
  - Required: sd_rd with lba 65..77.
- Writes to slots 2 and 7 on track 3, then track → 4:
  - Required: sd_wr at lba 41 then 46, dirty → 0.
  - Required: then sd_rd at lba 52..64.
- Readonly mount, write to slot 1, track change:
  - Required: dirty stays 0 and no sd_wr.
- img_mounted pulsed during load sector 4:
  - Required: sector 4 ack completes, then the load restarts at lba track*13.
  - Required: dirty = 0.
- reset_n low during LOAD_XFER:
  - Required: all outputs 0 immediately.
  - Required: after release, no request until the next img_mounted.

Source files
------------

// File: rtl/fdd_track_ctrl.sv
// fdd_track_ctrl: Disk II track-buffer sequencer.
// Writes back dirty sectors of the resident track and loads the new track
// into the floppy DPRAM over SD channel 0. The CPU is stalled while it works.
module fdd_track_ctrl #(
    parameter int SECTORS = 13,
    parameter int TRACK_W = 6
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic [TRACK_W-1:0] track,
    input  logic               img_mounted,
    input  logic               img_size_nz,
    input  logic               img_readonly,
    input  logic               fd_write_disk,
    input  logic [13:0]        fd_track_addr,
    output logic [31:0]        sd_lba,
    output logic               sd_rd,
    output logic               sd_wr,
    input  logic               sd_ack,
    output logic [3:0]         buf_sec,
    output logic               cpu_wait,
    output logic [SECTORS-1:0] dirty
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FLUSH_REQ  = 3'd1,
        ST_FLUSH_XFER = 3'd2,
        ST_LOAD_REQ   = 3'd3,
        ST_LOAD_XFER  = 3'd4
    } state_t;

    localparam logic [4:0] SEC_LIMIT = 5'(SECTORS);
    localparam logic [3:0] SEC_LAST  = 4'(SECTORS - 1);
    localparam logic [9:0] SEC_MUL   = 10'(SECTORS);

    state_t               state_q, state_d;
    logic                 mounted_q, mounted_d;
    logic                 ro_q, ro_d;
    logic [TRACK_W-1:0]   cur_track_q, cur_track_d;
    logic [SECTORS-1:0]   dirty_q, dirty_d;
    logic [3:0]           sec_q, sec_d;
    logic                 mount_pend_q, mount_pend_d;
    logic                 old_ack_q;
    logic                 sd_rd_q, sd_rd_d;
    logic                 sd_wr_q, sd_wr_d;
    logic                 cpu_wait_q, cpu_wait_d;
    logic [9:0]           sd_lba_q, sd_lba_d;

    logic                 ack_rise;
    logic                 ack_fall;
    logic                 mount_evt;
    logic [3:0]           wr_slot;
    logic                 wr_hit;
    logic [SECTORS-1:0]   dirty_w;

    // Only the sector slot of the buffer address matters here.
    logic unused_addr;
    assign unused_addr = ^{fd_track_addr[13], fd_track_addr[8:0]};

    // One-hot mask for a sector slot; slots beyond the track give an empty mask.
    function automatic logic [SECTORS-1:0] slot_mask(input logic [3:0] slot);
        logic [SECTORS-1:0] m;
        m = '0;
        for (int i = 0; i < SECTORS; i++) begin
            m[i] = (slot == 4'(i));
        end
        return m;
    endfunction

    // Index of the lowest set bit (0 when the mask is empty).
    function automatic logic [3:0] lowest_idx(input logic [SECTORS-1:0] m);
        logic [3:0] r;
        r = '0;
        for (int i = SECTORS - 1; i >= 0; i--) begin
            if (m[i]) begin
                r = 4'(i);
            end
        end
        return r;
    endfunction

    // Sector LBA: track*SECTORS + sector, 10 bits covers the largest image.
    function automatic logic [9:0] track_lba(input logic [TRACK_W-1:0] t,
                                             input logic [3:0]         s);
        return 10'(t) * SEC_MUL + 10'(s);
    endfunction

    assign ack_rise  = sd_ack & ~old_ack_q;
    assign ack_fall  = ~sd_ack & old_ack_q;
    assign mount_evt = mount_pend_q | img_mounted;
    assign wr_slot   = fd_track_addr[12:9];
    assign wr_hit    = fd_write_disk & mounted_q & ~ro_q & ({1'b0, wr_slot} < SEC_LIMIT);

    // Next-state, dirty tracking, mount latching and registered output values.
    always_comb begin
        state_d      = state_q;
        mounted_d    = mounted_q;
        ro_d         = ro_q;
        cur_track_d  = cur_track_q;
        dirty_d      = dirty_q;
        sec_d        = sec_q;
        mount_pend_d = mount_pend_q;
        dirty_w      = dirty_q;

        if (img_mounted) begin
            mounted_d = img_size_nz;
            ro_d      = img_readonly;
        end

        case (state_q)
            ST_IDLE: begin
                // A strobe in the cycle IDLE is left still counts toward the flush.
                if (wr_hit) begin
                    dirty_w = dirty_q | slot_mask(wr_slot);
                end
                dirty_d = dirty_w;
                if (mount_evt) begin
                    // A new image invalidates the buffer: nothing to write back.
                    mount_pend_d = 1'b0;
                    dirty_d      = '0;
                    if (mounted_d) begin
                        cur_track_d = track;
                        sec_d       = '0;
                        state_d     = ST_LOAD_REQ;
                    end
                end else if (track != cur_track_q) begin
                    if (mounted_q) begin
                        if (dirty_w != '0) begin
                            // cur_track keeps the old track until the flush is done.
                            sec_d   = lowest_idx(dirty_w);
                            state_d = ST_FLUSH_REQ;
                        end else begin
                            cur_track_d = track;
                            sec_d       = '0;
                            state_d     = ST_LOAD_REQ;
                        end
                    end else begin
                        cur_track_d = track;
                    end
                end
            end
            ST_FLUSH_REQ: begin
                if (ack_rise) begin
                    dirty_d = dirty_q & ~slot_mask(sec_q);
                    state_d = ST_FLUSH_XFER;
                end
            end
            ST_FLUSH_XFER: begin
                if (ack_fall) begin
                    if (mount_evt) begin
                        // Remaining write-backs belong to the old image.
                        dirty_d = '0;
                        state_d = ST_IDLE;
                    end else if (dirty_q != '0) begin
                        sec_d   = lowest_idx(dirty_q);
                        state_d = ST_FLUSH_REQ;
                    end else begin
                        cur_track_d = track;
                        sec_d       = '0;
                        state_d     = ST_LOAD_REQ;
                    end
                end
            end
            ST_LOAD_REQ: begin
                if (ack_rise) begin
                    state_d = ST_LOAD_XFER;
                end
            end
            ST_LOAD_XFER: begin
                if (ack_fall) begin
                    if (mount_evt || sec_q == SEC_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        sec_d   = sec_q + 4'd1;
                        state_d = ST_LOAD_REQ;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Mounts arriving mid-sequence are remembered until IDLE handles them.
        if (img_mounted && state_q != ST_IDLE) begin
            mount_pend_d = 1'b1;
        end

        sd_rd_d    = (state_d == ST_LOAD_REQ);
        sd_wr_d    = (state_d == ST_FLUSH_REQ);
        // Stay stalled across a pass through IDLE that will immediately restart.
        cpu_wait_d = (state_d != ST_IDLE) | mount_pend_d
                   | (mounted_d & (track != cur_track_d));
        sd_lba_d   = track_lba(cur_track_d, sec_d);
    end

    // State and output registers; reset drops requests at once.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            mounted_q    <= 1'b0;
            ro_q         <= 1'b0;
            cur_track_q  <= '0;
            dirty_q      <= '0;
            sec_q        <= '0;
            mount_pend_q <= 1'b0;
            old_ack_q    <= 1'b0;
            sd_rd_q      <= 1'b0;
            sd_wr_q      <= 1'b0;
            cpu_wait_q   <= 1'b0;
            sd_lba_q     <= '0;
        end else begin
            state_q      <= state_d;
            mounted_q    <= mounted_d;
            ro_q         <= ro_d;
            cur_track_q  <= cur_track_d;
            dirty_q      <= dirty_d;
            sec_q        <= sec_d;
            mount_pend_q <= mount_pend_d;
            old_ack_q    <= sd_ack;
            sd_rd_q      <= sd_rd_d;
            sd_wr_q      <= sd_wr_d;
            cpu_wait_q   <= cpu_wait_d;
            sd_lba_q     <= sd_lba_d;
        end
    end

    assign sd_lba   = {22'd0, sd_lba_q};
    assign sd_rd    = sd_rd_q;
    assign sd_wr    = sd_wr_q;
    assign buf_sec  = sec_q;
    assign cpu_wait = cpu_wait_q;
    assign dirty    = dirty_q;

endmodule

// File: tb/tb_fdd_track_ctrl.sv
// tb_fdd_track_ctrl: directed + randomized bench with an SD-side responder
// and a transaction-list reference model of the expected sector traffic.
module tb_fdd_track_ctrl;

    localparam int SECTORS = 13;
    localparam int TRACK_W = 6;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [5:0]  track = '0;
    logic        img_mounted = 1'b0;
    logic        img_size_nz = 1'b0;
    logic        img_readonly = 1'b0;
    logic        fd_write_disk = 1'b0;
    logic [13:0] fd_track_addr = '0;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack = 1'b0;
    logic [3:0]  buf_sec;
    logic        cpu_wait;
    logic [12:0] dirty;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_mounted;
    bit          m_ro;
    int          m_track;
    logic [12:0] m_dirty;
    int          q_lba[$];
    bit          q_wr[$];
    int          q_sec[$];

    fdd_track_ctrl #(.SECTORS(SECTORS), .TRACK_W(TRACK_W)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .track(track),
        .img_mounted(img_mounted), .img_size_nz(img_size_nz),
        .img_readonly(img_readonly), .fd_write_disk(fd_write_disk),
        .fd_track_addr(fd_track_addr), .sd_lba(sd_lba), .sd_rd(sd_rd),
        .sd_wr(sd_wr), .sd_ack(sd_ack), .buf_sec(buf_sec),
        .cpu_wait(cpu_wait), .dirty(dirty)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic push_loads(input int trk);
        for (int s = 0; s < SECTORS; s++) begin
            q_lba.push_back(trk * SECTORS + s);
            q_wr.push_back(1'b0);
            q_sec.push_back(s);
        end
    endtask

    task automatic push_flush(input int trk, input logic [12:0] d);
        for (int s = 0; s < SECTORS; s++) begin
            if (d[s]) begin
                q_lba.push_back(trk * SECTORS + s);
                q_wr.push_back(1'b1);
                q_sec.push_back(s);
            end
        end
    endtask

    task automatic do_mount(input bit nz, input bit ro);
        img_size_nz  = nz;
        img_readonly = ro;
        img_mounted  = 1'b1;
        step();
        img_mounted  = 1'b0;
        m_mounted = nz;
        m_ro      = ro;
        m_dirty   = '0;
        m_track   = int'(track);
        if (nz) push_loads(m_track);
    endtask

    task automatic set_track(input int t);
        track = 6'(t);
        if (m_mounted && t != m_track) begin
            push_flush(m_track, m_dirty);
            m_dirty = '0;
            push_loads(t);
        end
        m_track = t;
    endtask

    task automatic write_slot(input int slot);
        fd_track_addr = {1'b0, 4'(slot), 9'($urandom_range(0, 511))};
        fd_write_disk = 1'b1;
        step();
        fd_write_disk = 1'b0;
        if (m_mounted && !m_ro && slot < SECTORS) m_dirty[slot] = 1'b1;
        check("dirty_after_write", 32'(dirty), 32'(m_dirty));
    endtask

    // Act as the SD card for one sector: wait for the request, check it, handshake.
    task automatic serve_one(input int lba, input bit wr, input int sec, input bit pulse_mount);
        bit seen;
        int k;
        seen = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (sd_rd || sd_wr) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check("req_seen", 32'(seen), 32'd1);
        if (!seen) return;
        check("req_wr", 32'(sd_wr), 32'(wr));
        check("req_rd", 32'(sd_rd), 32'(!wr));
        check("req_lba", sd_lba, 32'(lba));
        check("req_buf_sec", 32'(buf_sec), 32'(sec));
        check("req_cpu_wait", 32'(cpu_wait), 32'd1);
        repeat ($urandom_range(0, 3)) step();
        check("req_held", 32'(sd_rd | sd_wr), 32'd1);
        sd_ack = 1'b1;
        step();
        check("req_dropped", 32'({sd_rd, sd_wr}), 32'd0);
        k = $urandom_range(1, 4);
        for (int i = 0; i < k; i++) begin
            if (pulse_mount && i == 0) begin
                img_mounted = 1'b1;
                step();
                img_mounted = 1'b0;
            end else begin
                step();
            end
        end
        check("xfer_lba_stable", sd_lba, 32'(lba));
        check("xfer_sec_stable", 32'(buf_sec), 32'(sec));
        check("xfer_cpu_wait", 32'(cpu_wait), 32'd1);
        sd_ack = 1'b0;
        step();
    endtask

    // Serve every queued transaction; pulse_at >= 0 injects a mount at that sector.
    task automatic run_queue(input int pulse_at);
        int idx;
        int lba;
        bit wr;
        int sec;
        idx = 0;
        while (q_lba.size() > 0) begin
            lba = q_lba.pop_front();
            wr  = q_wr.pop_front();
            sec = q_sec.pop_front();
            serve_one(lba, wr, sec, idx == pulse_at);
            if (idx == pulse_at) begin
                q_lba.delete();
                q_wr.delete();
                q_sec.delete();
                m_dirty = '0;
                push_loads(m_track);
            end
            idx++;
        end
        check("end_cpu_wait", 32'(cpu_wait), 32'd0);
        check("end_dirty", 32'(dirty), 32'(m_dirty));
        repeat (4) begin
            step();
            check("no_extra_req", 32'({sd_rd, sd_wr}), 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sd_rd"}, 32'(sd_rd), 32'd0);
        check({tag, "_sd_wr"}, 32'(sd_wr), 32'd0);
        check({tag, "_cpu_wait"}, 32'(cpu_wait), 32'd0);
        check({tag, "_sd_lba"}, sd_lba, 32'd0);
        check({tag, "_buf_sec"}, 32'(buf_sec), 32'd0);
        check({tag, "_dirty"}, 32'(dirty), 32'd0);
    endtask

    initial begin
        int t;
        int nw;
        m_mounted = 1'b0;
        m_ro      = 1'b0;
        m_track   = 0;
        m_dirty   = '0;

        // Reset state
        #3;
        check_all_zero("reset");
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b1;
        step();

        // Mount rw at track 0: full load of lba 0..12
        track = 6'd0;
        do_mount(1'b1, 1'b0);
        run_queue(-1);

        // Clean track change 0 -> 5: loads only
        set_track(5);
        run_queue(-1);

        // Dirty slots 2 and 7 on track 3, slot 14 ignored, then move to track 4
        set_track(3);
        run_queue(-1);
        write_slot(2);
        write_slot(7);
        write_slot(14);
        set_track(4);
        run_queue(-1);

        // Randomized write/track-change rounds
        for (int r = 0; r < 6; r++) begin
            nw = $urandom_range(0, 5);
            for (int w = 0; w < nw; w++) write_slot($urandom_range(0, 15));
            do t = $urandom_range(0, 63); while (t == m_track);
            set_track(t);
            run_queue(-1);
        end

        // Read-only image: writes never mark sectors dirty
        do_mount(1'b1, 1'b1);
        run_queue(-1);
        write_slot(1);
        do t = $urandom_range(0, 63); while (t == m_track);
        set_track(t);
        run_queue(-1);

        // Mount coinciding with a track change after writes: mount wins, no flush
        do_mount(1'b1, 1'b0);
        run_queue(-1);
        write_slot(3);
        write_slot(9);
        do t = $urandom_range(0, 63); while (t == m_track);
        track = 6'(t);
        do_mount(1'b1, 1'b0);
        run_queue(-1);

        // Mount pulse during load sector 4: restart at track*13
        do_mount(1'b1, 1'b0);
        run_queue(4);

        // Reset asserted in LOAD_XFER
        do t = $urandom_range(1, 63); while (t == m_track);
        set_track(t);
        serve_one(q_lba.pop_front(), q_wr.pop_front(), q_sec.pop_front(), 1'b0);
        void'(q_wr.pop_front());
        void'(q_sec.pop_front());
        void'(q_lba.pop_front());
        begin
            bit seen;
            seen = 1'b0;
            for (int n = 0; n < 60; n++) begin
                if (sd_rd) begin
                    seen = 1'b1;
                    break;
                end
                step();
            end
            check("rst_req_seen", 32'(seen), 32'd1);
        end
        sd_ack = 1'b1;
        step();
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        sd_ack = 1'b0;
        q_lba.delete();
        q_wr.delete();
        q_sec.delete();
        m_mounted = 1'b0;
        m_ro      = 1'b0;
        m_dirty   = '0;
        step();
        @(negedge clk_sys);
        reset_n = 1'b1;
        step();
        track = 6'($urandom_range(0, 63));
        m_track = int'(track);
        repeat (8) begin
            step();
            check("post_reset_idle", 32'({sd_rd, sd_wr, cpu_wait}), 32'd0);
        end

        // Empty image: mounted stays low, no traffic
        do_mount(1'b0, 1'b0);
        repeat (6) begin
            step();
            check("empty_mount_idle", 32'({sd_rd, sd_wr, cpu_wait}), 32'd0);
        end

        // Real mount after reset resumes normal loading
        do_mount(1'b1, 1'b0);
        run_queue(-1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
